link_tx: RTL and testbench

Credit-based link transmitter that drains a router input/output FIFO and drives flits onto a point-to-point link toward a downstream router's FIFO. It sits on the read side of a show-ahead FIFO: it observes `fifo_out`/`fifo_empty`, asserts `fifo_consume`, and tracks free downstream slots through returned credits. Packets are sent atomically: once a head flit leaves, only that packet's flits follow until its tail.

---
 rtl/link_pkg.sv | 16 +
 rtl/link_if.sv | 37 +++
 rtl/credit_counter.sv | 42 ++++
 rtl/link_tx.sv | 104 ++++++++++
 tb/tb_link_tx.sv | 243 ++++++++++++++++++++++++
 5 files changed

// File: rtl/link_pkg.sv
// Shared definitions for the credit-based link transmitter: flit flag
// offsets, FSM state type and default credit depth.
package link_pkg;

  localparam int CREDIT_MAX = 8;

  // Flag bit positions are offsets below the flit width (flit[width - offset]).
  localparam int TAIL_BIT = 1;
  localparam int HEAD_BIT = 2;

  typedef enum logic {
    IDLE   = 1'b0,
    IN_PKT = 1'b1
  } tx_state_t;

endpackage

// File: rtl/link_if.sv
// Bundle of the FIFO read side, link output and status signals of link_tx.
// master = transmitter, slave = surrounding FIFO / link / monitor.
//
// Handshake: fifo_out is valid whenever fifo_empty is low (show-ahead); the
// transmitter pops it by raising fifo_consume in that same cycle, and never
// raises fifo_consume while fifo_empty is high. On the link there is no
// ready: tx_flit is taken by the receiver in every cycle tx_valid is high,
// and flow control is handled purely by credits (one credit_in pulse per
// freed downstream slot).
interface link_if #(
  parameter int flit_width   = 64,
  parameter int credit_width = 4
);

  logic [flit_width-1:0]   fifo_out;
  logic                    fifo_empty;
  logic                    fifo_consume;
  logic                    link_en;
  logic                    credit_in;
  logic                    tx_valid;
  logic [flit_width-1:0]   tx_flit;
  logic [credit_width-1:0] credits;
  logic                    in_packet;
  logic                    err;
  link_pkg::tx_state_t     state;

  modport master (
    input  fifo_out, fifo_empty, link_en, credit_in,
    output fifo_consume, tx_valid, tx_flit, credits, in_packet, err, state
  );

  modport slave (
    output fifo_out, fifo_empty, link_en, credit_in,
    input  fifo_consume, tx_valid, tx_flit, credits, in_packet, err, state
  );

endinterface

// File: rtl/credit_counter.sv
// Saturating up/down credit counter; resets to a full downstream buffer and
// flags a returned credit that would exceed that depth.
module credit_counter #(
  parameter int credit_max   = 8,
  parameter int credit_width = 4
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    dec,
  input  logic                    inc,
  output logic [credit_width-1:0] count,
  output logic                    zero,
  output logic                    overflow
);

  localparam logic [credit_width-1:0] MAX = credit_width'(credit_max);
  localparam logic [credit_width-1:0] ONE = credit_width'(1);

  logic [credit_width-1:0] r_count;
  logic [credit_width-1:0] w_next;

  // A simultaneous inc and dec cancel out and never count as overflow.
  always_comb begin
    w_next   = r_count;
    overflow = 1'b0;
    if (inc && !dec) begin
      if (r_count == MAX) overflow = 1'b1;
      else                w_next   = r_count + ONE;
    end else if (dec && !inc) begin
      if (r_count != '0) w_next = r_count - ONE;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) r_count <= MAX;
    else     r_count <= w_next;
  end

  assign count = r_count;
  assign zero  = (r_count == '0);

endmodule

// File: rtl/link_tx.sv
// Credit-based link transmitter: drains a show-ahead FIFO onto a link,
// keeping packets atomic and dropping stray non-head flits between packets.
module link_tx
  import link_pkg::*;
#(
  parameter int flit_width   = 64,
  parameter int credit_max   = CREDIT_MAX,
  parameter int credit_width = 4
) (
  input  logic  clk,
  input  logic  rst,
  link_if.master lnk
);

  tx_state_t r_state;
  tx_state_t w_state_next;

  logic                    w_head;
  logic                    w_tail;
  logic                    w_head_ok;
  logic                    w_body_ok;
  logic                    w_send;
  logic                    w_drop;
  logic                    w_err_set;
  logic                    w_zero;
  logic                    w_overflow;
  logic [credit_width-1:0] w_credits;

  logic                    r_tx_valid;
  logic [flit_width-1:0]   r_tx_flit;
  logic                    r_err;

  assign w_head = lnk.fifo_out[flit_width-HEAD_BIT];
  assign w_tail = lnk.fifo_out[flit_width-TAIL_BIT];

  credit_counter #(
    .credit_max   (credit_max),
    .credit_width (credit_width)
  ) u_credits (
    .clk      (clk),
    .rst      (rst),
    .dec      (w_send),
    .inc      (lnk.credit_in),
    .count    (w_credits),
    .zero     (w_zero),
    .overflow (w_overflow)
  );

  always_ff @(posedge clk) begin
    if (rst) r_state <= IDLE;
    else     r_state <= w_state_next;
  end

  // Any sent flit decides the next state by its tail flag alone: a tail
  // (including a single-flit head+tail packet) ends up in IDLE.
  always_comb begin
    w_state_next = r_state;
    if (w_send) w_state_next = w_tail ? IDLE : IN_PKT;
  end

  // link_en only gates the start of a packet; credits gate every flit.
  always_comb begin
    w_head_ok = !lnk.fifo_empty && w_head && lnk.link_en && !w_zero;
    w_body_ok = !lnk.fifo_empty && !w_zero;
    w_send    = 1'b0;
    w_drop    = 1'b0;
    w_err_set = 1'b0;
    case (r_state)
      IDLE: begin
        w_send    = w_head_ok;
        w_drop    = !lnk.fifo_empty && !w_head;
        w_err_set = w_drop;
      end
      IN_PKT: begin
        w_send    = w_body_ok;
        w_err_set = w_body_ok && w_head;
      end
      default: begin
        w_send = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_tx_valid <= 1'b0;
      r_tx_flit  <= '0;
      r_err      <= 1'b0;
    end else begin
      r_tx_valid <= w_send;
      if (w_send) r_tx_flit <= lnk.fifo_out;
      r_err <= r_err | w_err_set | w_overflow;
    end
  end

  assign lnk.fifo_consume = w_send | w_drop;
  assign lnk.tx_valid     = r_tx_valid;
  assign lnk.tx_flit      = r_tx_flit;
  assign lnk.credits      = w_credits;
  assign lnk.in_packet    = (r_state == IN_PKT);
  assign lnk.err          = r_err;
  assign lnk.state        = r_state;

endmodule

// File: tb/tb_link_tx.sv
// Self-checking bench for link_tx: a queue-based source FIFO, a flit-stream
// reference model feeding an expected queue, and a separate link monitor.
module tb_link_tx;

  localparam int FW = 64;
  localparam int CM = 8;
  localparam int CW = 4;

  logic clk = 1'b0;
  logic rst = 1'b1;

  always #5 clk = ~clk;

  link_if #(.flit_width(FW), .credit_width(CW)) bus ();

  link_tx #(
    .flit_width   (FW),
    .credit_max   (CM),
    .credit_width (CW)
  ) dut (
    .clk (clk),
    .rst (rst),
    .lnk (bus)
  );

  logic [FW-1:0] fifo_q[$];
  logic [FW-1:0] exp_q[$];
  logic [FW-1:0] last_tx = '0;

  int errors = 0;
  int checks = 0;

  bit m_in_pkt     = 1'b0;
  bit m_err        = 1'b0;
  int m_cred       = CM;
  bit last_ci      = 1'b0;
  bit last_consume = 1'b0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [FW-1:0] mk_flit(input bit head, input bit tail);
    logic [FW-1:0] f;
    f = {$urandom, $urandom};
    f[FW-1] = tail;
    f[FW-2] = head;
    return f;
  endfunction

  task automatic push_pkt(input int n, input bit stray_head);
    for (int i = 0; i < n; i++)
      fifo_q.push_back(mk_flit((i == 0) || (stray_head && i == 1), i == n - 1));
  endtask

  // One clock cycle: account for the previous edge in the model, check
  // registered state, drive new inputs, then check the pop strobe.
  // ci_mode: 0 = no credit, 1 = force a credit, 2 = random credit that
  // never exceeds the downstream depth.
  task automatic step(input bit r, input bit le, input int ci_mode);
    bit            ci;
    bit            sent;
    bit            exp_c;
    int            nc;
    logic [FW-1:0] f;
    @(negedge clk);
    if (rst) begin
      fifo_q.delete();
      exp_q.delete();
      m_in_pkt = 1'b0;
      m_err    = 1'b0;
      m_cred   = CM;
      last_tx  = '0;
    end else begin
      sent = 1'b0;
      if (last_consume && fifo_q.size() != 0) begin
        f = fifo_q.pop_front();
        if (!m_in_pkt && !f[FW-2]) begin
          m_err = 1'b1;
        end else begin
          sent = 1'b1;
          if (m_in_pkt && f[FW-2]) m_err = 1'b1;
          m_in_pkt = !f[FW-1];
          exp_q.push_back(f);
        end
      end
      nc = m_cred - int'(sent) + int'(last_ci);
      if (nc > CM) begin
        nc    = CM;
        m_err = 1'b1;
      end
      m_cred = nc;
    end
    chk("credits", 64'(bus.credits), 64'(m_cred));
    chk("in_packet", 64'(bus.in_packet), 64'(m_in_pkt));
    chk("err", 64'(bus.err), 64'(m_err));

    ci = (ci_mode == 1) || (ci_mode == 2 && m_cred < CM && $urandom_range(0, 2) == 0);
    rst            = r;
    bus.link_en    = le;
    bus.credit_in  = ci;
    last_ci        = ci && !r;
    bus.fifo_empty = (fifo_q.size() == 0);
    bus.fifo_out   = (fifo_q.size() == 0) ? {$urandom, $urandom} : fifo_q[0];
    #1;
    last_consume = bus.fifo_consume && !r;
    if (!r) begin
      if (fifo_q.size() == 0)  exp_c = 1'b0;
      else if (!m_in_pkt)      exp_c = fifo_q[0][FW-2] ? (le && m_cred != 0) : 1'b1;
      else                     exp_c = (m_cred != 0);
      chk("fifo_consume", 64'(bus.fifo_consume), 64'(exp_c));
    end
  endtask

  // Link monitor: every valid flit must be the next one the model expects.
  always @(negedge clk) begin
    #2;
    if (bus.tx_valid === 1'b1) begin
      if (exp_q.size() == 0) begin
        chk("tx_unexpected", bus.tx_flit, '0);
        if (bus.tx_flit === '0) begin
          errors++;
          $display("FAIL tx_unexpected: got valid flit %0h expected none", bus.tx_flit);
        end
      end else begin
        chk("tx_flit", bus.tx_flit, exp_q.pop_front());
      end
      last_tx = bus.tx_flit;
    end else begin
      chk("tx_hold", bus.tx_flit, last_tx);
    end
    chk("tx_missing", 64'(exp_q.size()), 64'(0));
  end

  initial begin
    int r;
    bus.link_en    = 1'b0;
    bus.credit_in  = 1'b0;
    bus.fifo_empty = 1'b1;
    bus.fifo_out   = '0;

    // Reset state
    step(1, 0, 0);
    step(0, 0, 0);
    chk("reset_credits", 64'(bus.credits), 64'(CM));
    chk("reset_tx_valid", 64'(bus.tx_valid), 64'(0));
    chk("reset_tx_flit", bus.tx_flit, 64'(0));
    chk("reset_in_packet", 64'(bus.in_packet), 64'(0));
    chk("reset_err", 64'(bus.err), 64'(0));

    // 3-flit packet, no credit return
    push_pkt(3, 0);
    repeat (5) step(0, 1, 0);
    chk("pkt3_credits", 64'(bus.credits), 64'(5));
    chk("pkt3_in_packet", 64'(bus.in_packet), 64'(0));
    repeat (5) step(0, 0, 1);
    step(0, 0, 0);

    // 10-flit packet stalls after 8, one credit releases the 9th
    push_pkt(10, 0);
    repeat (12) step(0, 1, 0);
    chk("stall_credits", 64'(bus.credits), 64'(0));
    chk("stall_left", 64'(fifo_q.size()), 64'(2));
    step(0, 1, 1);
    repeat (3) step(0, 1, 0);
    chk("ninth_left", 64'(fifo_q.size()), 64'(1));
    repeat (9) step(0, 0, 1);
    repeat (2) step(0, 0, 0);
    chk("refill_credits", 64'(bus.credits), 64'(CM));

    // link_en low holds a head; dropping it mid-packet does not stall
    push_pkt(4, 0);
    repeat (3) step(0, 0, 0);
    chk("no_grant_left", 64'(fifo_q.size()), 64'(4));
    step(0, 1, 0);
    repeat (5) step(0, 0, 0);
    chk("mid_drop_left", 64'(fifo_q.size()), 64'(0));
    chk("mid_drop_credits", 64'(bus.credits), 64'(4));
    repeat (4) step(0, 0, 1);
    step(0, 0, 0);

    // Stray body flit in IDLE is dropped and flagged
    fifo_q.push_back(mk_flit(0, 0));
    repeat (3) step(0, 1, 0);
    chk("drop_err", 64'(bus.err), 64'(1));
    chk("drop_credits", 64'(bus.credits), 64'(CM));
    step(1, 0, 0);
    step(0, 0, 0);
    chk("err_cleared", 64'(bus.err), 64'(0));

    // Credit return at full count saturates and flags
    step(0, 0, 1);
    step(0, 0, 0);
    chk("ovf_credits", 64'(bus.credits), 64'(CM));
    chk("ovf_err", 64'(bus.err), 64'(1));
    step(1, 0, 0);
    step(0, 0, 0);

    // Send and credit return together at count 3
    push_pkt(7, 0);
    repeat (5) step(0, 1, 0);
    step(0, 1, 1);
    step(0, 1, 0);
    chk("send_and_return", 64'(bus.credits), 64'(3));
    step(0, 0, 0);
    repeat (6) step(0, 0, 1);
    step(0, 0, 0);

    // Reset in the middle of a 4-flit packet
    push_pkt(4, 0);
    repeat (2) step(0, 1, 0);
    step(1, 1, 0);
    step(0, 0, 0);
    chk("rst_mid_credits", 64'(bus.credits), 64'(CM));
    chk("rst_mid_in_packet", 64'(bus.in_packet), 64'(0));
    chk("rst_mid_tx_valid", 64'(bus.tx_valid), 64'(0));
    chk("rst_mid_err", 64'(bus.err), 64'(0));

    // Random traffic with occasional protocol violations
    for (int cyc = 0; cyc < 800; cyc++) begin
      if (fifo_q.size() < 4 && $urandom_range(0, 3) == 0) begin
        r = $urandom_range(0, 9);
        if (r == 0)      fifo_q.push_back(mk_flit(0, 1'($urandom_range(0, 1))));
        else if (r == 1) push_pkt($urandom_range(3, 6), 1);
        else             push_pkt($urandom_range(1, 6), 0);
      end
      step(0, $urandom_range(0, 3) != 0, 2);
    end
    for (int i = 0; i < 300 && (fifo_q.size() != 0 || m_cred != CM); i++)
      step(0, 1, 2);
    repeat (2) step(0, 0, 0);
    chk("drain_left", 64'(fifo_q.size()), 64'(0));
    chk("drain_credits", 64'(bus.credits), 64'(CM));

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
